// File: rtl/regfile_2r1w_sb.sv
// Purpose: 2-read/1-write register file with write-through bypass and a per-register pending scoreboard.
// Latency: reads and busy flags are combinational; writes, pending bits and pend_cnt update on the rising clk edge.
// Backpressure: none; every write and issue presented is accepted on the edge.
module regfile_2r1w_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_dst,
    output logic              busy1,
    output logic              busy2,
    output logic              busy_dst,
    output logic [ADDR_W:0]   pend_cnt
);

    localparam int NREG = 1 << ADDR_W;

    logic [NREG-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [NREG-1:0]             pend_q, pend_d;
    logic [ADDR_W:0]             pend_cnt_q, pend_cnt_d;

    logic wr_hit;
    logic iss_hit;

    assign wr_hit  = we && (wa != '0);
    assign iss_hit = iss_valid && (iss_dst != '0);

    // Set is applied after clear so a same-register issue keeps the new producer outstanding.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        if (wr_hit) begin
            regs_d[wa] = wd;
            pend_d[wa] = 1'b0;
        end
        if (iss_hit) begin
            pend_d[iss_dst] = 1'b1;
        end
        regs_d[0] = '0;
        pend_d[0] = 1'b0;
    end

    always_comb begin
        pend_cnt_d = '0;
        for (int i = 0; i < NREG; i++) begin
            pend_cnt_d = pend_cnt_d + {{ADDR_W{1'b0}}, pend_d[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q     <= '0;
            pend_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            pend_q     <= pend_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    always_comb begin
        rd1 = regs_q[ra1];
        rd2 = regs_q[ra2];
        if (wr_hit && (wa == ra1)) begin
            rd1 = wd;
        end
        if (wr_hit && (wa == ra2)) begin
            rd2 = wd;
        end
        if (ra1 == '0) begin
            rd1 = '0;
        end
        if (ra2 == '0) begin
            rd2 = '0;
        end
    end

    // A same-cycle writeback releases the read hazard together with the bypass.
    assign busy1    = pend_q[ra1] & ~(we && (wa == ra1));
    assign busy2    = pend_q[ra2] & ~(we && (wa == ra2));
    assign busy_dst = pend_q[iss_dst];
    assign pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Directed bench for regfile_2r1w_sb: vector table for single-cycle behaviour, hand sequences for reset and fill.
module tb_regfile_2r1w_sb;

    logic        clk;
    logic        rst_n;
    logic [4:0]  ra1, ra2, wa, iss_dst;
    logic [31:0] rd1, rd2, wd;
    logic        we, iss_valid;
    logic        busy1, busy2, busy_dst;
    logic [5:0]  pend_cnt;

    int nvec = 0;
    int nerr = 0;

    regfile_2r1w_sb #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra1      (ra1),
        .ra2      (ra2),
        .rd1      (rd1),
        .rd2      (rd2),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .iss_valid(iss_valid),
        .iss_dst  (iss_dst),
        .busy1    (busy1),
        .busy2    (busy2),
        .busy_dst (busy_dst),
        .pend_cnt (pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  ra1, ra2;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        iv;
        logic [4:0]  idst;
        logic [31:0] e_rd1, e_rd2;
        logic        e_b1, e_b2, e_bd;
        logic [5:0]  e_cnt;
    } vec_t;

    function automatic vec_t mk(input logic [4:0] a1, a2, input logic w, input logic [4:0] wadr,
                                input logic [31:0] wdat, input logic v, input logic [4:0] d,
                                input logic [31:0] r1, r2, input logic b1, b2, bd, input logic [5:0] c);
        vec_t t;
        t.ra1 = a1; t.ra2 = a2; t.we = w; t.wa = wadr; t.wd = wdat; t.iv = v; t.idst = d;
        t.e_rd1 = r1; t.e_rd2 = r2; t.e_b1 = b1; t.e_b2 = b2; t.e_bd = bd; t.e_cnt = c;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] a1, a2, input logic w, input logic [4:0] wadr,
                         input logic [31:0] wdat, input logic v, input logic [4:0] d);
        ra1 = a1; ra2 = a2; we = w; wa = wadr; wd = wdat; iss_valid = v; iss_dst = d;
    endtask

    vec_t tbl[19];

    initial begin
        // Expected outputs are those seen before the edge that applies the row's inputs.
        tbl[0]  = mk(0, 0, 1, 0, 32'hDEADBEEF, 0, 0,   32'h0, 32'h0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 5, 0, 0, 32'h0,        0, 0,   32'h0, 32'h0, 0, 0, 0, 0);
        tbl[2]  = mk(7, 0, 1, 7, 32'h12345678, 0, 0,   32'h12345678, 32'h0, 0, 0, 0, 0);
        tbl[3]  = mk(7, 7, 0, 0, 32'h0,        0, 0,   32'h12345678, 32'h12345678, 0, 0, 0, 0);
        tbl[4]  = mk(0, 9, 0, 0, 32'h0,        1, 9,   32'h0, 32'h0, 0, 0, 0, 0);
        tbl[5]  = mk(0, 9, 0, 0, 32'h0,        0, 0,   32'h0, 32'h0, 0, 1, 0, 1);
        tbl[6]  = mk(9, 9, 1, 9, 32'hA5,       0, 0,   32'hA5, 32'hA5, 0, 0, 0, 1);
        tbl[7]  = mk(0, 9, 0, 0, 32'h0,        0, 0,   32'h0, 32'hA5, 0, 0, 0, 0);
        tbl[8]  = mk(4, 0, 1, 4, 32'h55,       1, 4,   32'h55, 32'h0, 0, 0, 0, 0);
        tbl[9]  = mk(4, 0, 0, 0, 32'h0,        1, 4,   32'h55, 32'h0, 1, 0, 1, 1);
        tbl[10] = mk(4, 0, 1, 4, 32'h66,       1, 12,  32'h66, 32'h0, 0, 0, 0, 1);
        tbl[11] = mk(4, 12, 0, 0, 32'h0,       0, 0,   32'h66, 32'h0, 0, 1, 0, 1);
        tbl[12] = mk(0, 12, 1, 0, 32'hFFFFFFFF, 1, 0,  32'h0, 32'h0, 0, 1, 0, 1);
        tbl[13] = mk(0, 0, 0, 0, 32'h0,        0, 0,   32'h0, 32'h0, 0, 0, 0, 1);
        tbl[14] = mk(20, 0, 1, 20, 32'h20,     0, 0,   32'h20, 32'h0, 0, 0, 0, 1);
        tbl[15] = mk(20, 0, 0, 0, 32'h0,       0, 0,   32'h20, 32'h0, 0, 0, 0, 1);
        tbl[16] = mk(12, 0, 1, 3, 32'h3,       0, 0,   32'h0, 32'h0, 1, 0, 0, 1);
        tbl[17] = mk(12, 5, 1, 12, 32'hC,      1, 5,   32'hC, 32'h0, 0, 0, 0, 1);
        tbl[18] = mk(12, 5, 0, 0, 32'h0,       0, 0,   32'hC, 32'h0, 0, 1, 0, 1);

        drive(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("reset_pend_cnt", {26'd0, pend_cnt}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i);
            ra2 = 5'(31 - i);
            #1;
            check($sformatf("reset_read_%0d", i), {rd1 | rd2, 29'd0, busy1, busy2, busy_dst} == '0 ? 32'd0 : 32'd1, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            drive(tbl[i].ra1, tbl[i].ra2, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].iv, tbl[i].idst);
            #1;
            nvec++;
            if (rd1 !== tbl[i].e_rd1 || rd2 !== tbl[i].e_rd2 || busy1 !== tbl[i].e_b1 ||
                busy2 !== tbl[i].e_b2 || busy_dst !== tbl[i].e_bd || pend_cnt !== tbl[i].e_cnt) begin
                nerr++;
                $display("FAIL vec%0d: got rd1=%h rd2=%h b1=%b b2=%b bd=%b cnt=%0d expected rd1=%h rd2=%h b1=%b b2=%b bd=%b cnt=%0d",
                         i, rd1, rd2, busy1, busy2, busy_dst, pend_cnt,
                         tbl[i].e_rd1, tbl[i].e_rd2, tbl[i].e_b1, tbl[i].e_b2, tbl[i].e_bd, tbl[i].e_cnt);
            end
        end

        // Fill the scoreboard: pend[5] is already set from the table, so the count ends at 31.
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 1, 5'(i));
        end
        @(negedge clk);
        drive(7, 9, 0, 0, 0, 1, 31);
        #1;
        check("fill_pend_cnt", {26'd0, pend_cnt}, 32'd31);
        check("fill_busy_dst", {31'd0, busy_dst}, 32'd1);
        check("fill_rd1_r7", rd1, 32'h12345678);

        // Reset between edges with a write and an issue in flight.
        drive(7, 9, 1, 7, 32'hBAD, 1, 3);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_pend_cnt", {26'd0, pend_cnt}, 32'd0);
        check("midrst_busy_dst", {31'd0, busy_dst}, 32'd0);
        we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i);
            ra2 = 5'(i);
            #1;
            check($sformatf("midrst_read_%0d", i), rd1 | rd2, 32'd0);
        end
        we = 1'b1;
        @(negedge clk);
        check("rst_held_pend_cnt", {26'd0, pend_cnt}, 32'd0);
        rst_n = 1'b1;
        drive(7, 3, 1, 7, 32'h77, 1, 3);
        @(negedge clk);
        drive(7, 3, 0, 0, 0, 0, 0);
        #1;
        check("post_rst_rd1", rd1, 32'h77);
        check("post_rst_busy2", {31'd0, busy2}, 32'd1);
        check("post_rst_cnt", {26'd0, pend_cnt}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/regfile_2r1w_sb.md
Name: regfile_2r1w_sb

Overview:
- Register file for the datapath: 2^ADDR_W registers of DATA_W bits, two combinational read ports and one synchronous write port.
- Sits directly downstream of the 5-bit write-destination 2:1 mux, which selects rt or rd; the mux output drives wa and iss_dst.
- Contains a per-register pending scoreboard, so issue logic can detect read-after-write and write-after-write hazards against in-flight writebacks.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width. There are 2^ADDR_W registers; register 0 is hardwired to zero.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ra1  input  ADDR_W  read address, port 1.
- ra2  input  ADDR_W  read address, port 2.
- rd1  output  DATA_W  read data, port 1.
- rd2  output  DATA_W  read data, port 2.
- we  input  1  write enable (writeback valid).
- wa  input  ADDR_W  write address, from the destination mux.
- wd  input  DATA_W  write data.
- iss_valid  input  1  an instruction with a destination register issues this cycle.
- iss_dst  input  ADDR_W  destination of the issuing instruction.
- busy1  output  1  register ra1 has a pending write.
- busy2  output  1  register ra2 has a pending write.
- busy_dst  output  1  register iss_dst has a pending write (WAW).
- pend_cnt  output  ADDR_W+1  number of registers currently pending.

Behaviour:
- Reset (rst_n=0, asynchronous, no clock required):
  - all registers clear to 0;
  - all pending bits clear;
  - pend_cnt=0.
  - Reset asserted mid-operation discards any in-flight write or issue that cycle.
  - State changes resume on the first rising edge after rst_n deasserts.
- Write:
  - On the rising edge with we=1 and wa!=0, reg[wa] takes wd.
  - With wa=0 the write is ignored, and reg[0] always reads 0.
- Read:
  - Combinational; rd1=reg[ra1], rd2=reg[ra2].
  - Write-through bypass: if we=1, wa!=0 and wa==ra1, then rd1=wd in the same cycle. rd2 follows the same rule with ra2.
  - ra=0 always returns 0, even with a bypass hit.
- Outputs are a pure function of state and inputs. There is no output latency beyond the write-to-state edge.
- Scoreboard (one pending bit per register, bit 0 tied to 0):
  - Set on the edge when iss_valid=1 and iss_dst!=0.
  - Cleared on the edge when we=1 and wa!=0.
  - Simultaneous set and clear of the same register: the set wins, because the new producer stays outstanding; the data write still happens.
  - Set and clear on different registers are both applied.
  - A write to a non-pending register is legal: the data is written and the pending bit stays 0.
  - An issue to an already-pending register is legal: the bit stays 1 and busy_dst=1 flags it to issue logic.
- Busy flags:
  - busy1=pend[ra1] & ~(we & wa==ra1), so a same-cycle writeback releases the hazard together with the bypass. busy2 is analogous on ra2.
  - busy_dst=pend[iss_dst] with no writeback masking.
  - Address 0 never reports busy.
- pend_cnt:
  - Registered population count of the pending bits, updated on the same edge as the bits.
  - Range 0 to 2^ADDR_W-1; it cannot overflow because bit 0 never sets.

Test Plan:
- Reset, then read all 32 addresses. Write 0xDEADBEEF to r0 -> every rd=0, no busy flags, pend_cnt=0, and r0 reads 0 afterwards.
- Write 0x12345678 to r7 while ra1=7 in the same cycle -> rd1=0x12345678 combinationally (bypass); the next cycle rd1 is still 0x12345678 from storage.
- Issue dst=9, then ra2=9 -> busy2=1 and pend_cnt=1. Writeback we=1, wa=9, wd=0xA5 -> busy2=0 in that cycle, rd2=0xA5, pend_cnt=0 after the edge.
- In one cycle, iss_valid=1 with iss_dst=4 and we=1 with wa=4, wd=0x55 -> reg[4]=0x55, pend[4] stays 1, and busy_dst=1 on a later issue to 4.
- Issue to r1..r31 on consecutive cycles -> pend_cnt=31. Then assert rst_n=0 between clock edges -> pend_cnt=0 and all registers 0 immediately, without waiting for a clock.
- Issue dst=0 and write wa=0 with wd=0xFFFFFFFF -> pend_cnt unchanged, busy_dst=0, and reg[0] reads 0.
